// File: rtl/pre_trace_updater_if.sv
// Control and SRAM port bundle for pre_trace_updater; master is the sweeper side.
// Instantiate with the same N_PRE/ADDR_WIDTH/DATA_WIDTH as the attached updater.
interface pre_trace_updater_if #(
  parameter int N_PRE      = 256,
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32
);
  logic                  START;
  logic                  CLR_CNT;
  logic [N_PRE-1:0]      SPIKE_VEC;
  logic                  BUSY;
  logic                  DONE;
  logic                  SRAM_CS;
  logic                  SRAM_WE;
  logic [ADDR_WIDTH-1:0] SRAM_A;
  logic [DATA_WIDTH-1:0] SRAM_D;
  logic [DATA_WIDTH-1:0] SRAM_Q;

  modport master (
    input  START, CLR_CNT, SPIKE_VEC, SRAM_Q,
    output BUSY, DONE, SRAM_CS, SRAM_WE, SRAM_A, SRAM_D
  );

  modport slave (
    output START, CLR_CNT, SPIKE_VEC, SRAM_Q,
    input  BUSY, DONE, SRAM_CS, SRAM_WE, SRAM_A, SRAM_D
  );
endinterface

// File: rtl/pre_trace_updater.sv
// Per-time-step sweep over N_PRE pre-neuron state words: decay trace, add spikes, count.
// Read-modify-write per word, 2*N_PRE+1 cycles START->DONE; START while busy is dropped.
module pre_trace_updater #(
  parameter int          N_PRE       = 256,
  parameter int          ADDR_WIDTH  = 8,
  parameter int          DATA_WIDTH  = 32,
  parameter int          DECAY_SHIFT = 3,
  parameter logic [15:0] TRACE_INC   = 16'h1000
) (
  input logic                 CK,
  input logic                 RST_N,
  pre_trace_updater_if.master bus
);

  typedef enum logic [1:0] {IDLE, RD, WR, FIN} state_t;

  localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(N_PRE - 1);

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] idx_q, idx_d;
  logic [N_PRE-1:0]      spk_q, spk_d;
  logic                  clr_q, clr_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  cs_q, cs_d;
  logic                  we_q, we_d;
  logic [ADDR_WIDTH-1:0] a_q, a_d;

  logic                  spk_bit;
  logic [15:0]           trace_in;
  logic [15:0]           trace_dec;
  logic [16:0]           trace_sum;
  logic [15:0]           trace_new;
  logic [7:0]            cnt_base;
  logic [7:0]            cnt_new;
  logic [DATA_WIDTH-1:0] upd_word;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    spk_d   = spk_q;
    clr_d   = clr_q;
    case (state_q)
      IDLE: begin
        if (bus.START) begin
          spk_d   = bus.SPIKE_VEC;
          clr_d   = bus.CLR_CNT;
          idx_d   = '0;
          state_d = RD;
        end
      end
      RD:  state_d = WR;
      WR: begin
        if (idx_q == LAST_IDX) begin
          state_d = FIN;
        end else begin
          idx_d   = idx_q + ADDR_WIDTH'(1);
          state_d = RD;
        end
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Outputs are decoded from the next state so they come straight out of flops.
    busy_d = (state_d != IDLE);
    done_d = (state_d == FIN);
    cs_d   = (state_d == RD) || (state_d == WR);
    we_d   = (state_d == WR);
    a_d    = cs_d ? idx_d : '0;
  end

  always_comb begin
    spk_bit   = spk_q[idx_q];
    trace_in  = bus.SRAM_Q[31:16];
    // Shift truncates, so traces below 2^DECAY_SHIFT never decay.
    trace_dec = trace_in - (trace_in >> DECAY_SHIFT);
    trace_sum = {1'b0, trace_dec} + {1'b0, TRACE_INC};
    trace_new = trace_dec;
    if (spk_bit) begin
      trace_new = trace_sum[16] ? 16'hFFFF : trace_sum[15:0];
    end

    cnt_base = clr_q ? 8'h00 : bus.SRAM_Q[15:8];
    cnt_new  = cnt_base;
    if (spk_bit && (cnt_base != 8'hFF)) begin
      cnt_new = cnt_base + 8'h01;
    end

    upd_word = {trace_new, cnt_new, bus.SRAM_Q[7:0]};
  end

  always_ff @(posedge CK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= IDLE;
      idx_q   <= '0;
      spk_q   <= '0;
      clr_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      cs_q    <= 1'b0;
      we_q    <= 1'b0;
      a_q     <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      spk_q   <= spk_d;
      clr_q   <= clr_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      cs_q    <= cs_d;
      we_q    <= we_d;
      a_q     <= a_d;
    end
  end

  assign bus.BUSY    = busy_q;
  assign bus.DONE    = done_q;
  assign bus.SRAM_CS = cs_q;
  assign bus.SRAM_WE = we_q;
  assign bus.SRAM_A  = a_q;
  // Write data follows SRAM_Q within the WR cycle; gated so reset drives it to zero.
  assign bus.SRAM_D  = (state_q == WR) ? upd_word : '0;

endmodule

// File: tb/tb_pre_trace_updater.sv
// Directed bench: vector table over two sweeps, timing profile, mid-sweep reset, saturation.
module tb_pre_trace_updater;

  logic CK = 1'b0;
  logic RST_N = 1'b0;
  always #5 CK = ~CK;

  pre_trace_updater_if #(.N_PRE(256), .ADDR_WIDTH(8), .DATA_WIDTH(32)) u_bus ();
  pre_trace_updater_if #(.N_PRE(4),   .ADDR_WIDTH(2), .DATA_WIDTH(32)) u_bus2 ();

  pre_trace_updater #(.N_PRE(256), .ADDR_WIDTH(8), .DATA_WIDTH(32),
                      .DECAY_SHIFT(3), .TRACE_INC(16'h1000)) dut (
    .CK(CK), .RST_N(RST_N), .bus(u_bus.master));

  pre_trace_updater #(.N_PRE(4), .ADDR_WIDTH(2), .DATA_WIDTH(32),
                      .DECAY_SHIFT(3), .TRACE_INC(16'h4000)) dut2 (
    .CK(CK), .RST_N(RST_N), .bus(u_bus2.master));

  // SRAM models with a backdoor port for preloading while the sweepers are idle
  logic [31:0] mem [256];
  logic [31:0] mem2 [4];
  logic [31:0] q1, q2;
  logic        bd_we, bd2_we;
  logic [7:0]  bd_a;
  logic [1:0]  bd2_a;
  logic [31:0] bd_d, bd2_d;

  always @(posedge CK) begin
    if (bd_we) mem[bd_a] <= bd_d;
    else if (u_bus.SRAM_CS) begin
      if (u_bus.SRAM_WE) mem[u_bus.SRAM_A] <= u_bus.SRAM_D;
      else q1 <= mem[u_bus.SRAM_A];
    end
  end
  assign u_bus.SRAM_Q = q1;

  always @(posedge CK) begin
    if (bd2_we) mem2[bd2_a] <= bd2_d;
    else if (u_bus2.SRAM_CS) begin
      if (u_bus2.SRAM_WE) mem2[u_bus2.SRAM_A] <= u_bus2.SRAM_D;
      else q2 <= mem2[u_bus2.SRAM_A];
    end
  end
  assign u_bus2.SRAM_Q = q2;

  int done_cnt = 0;
  always @(negedge CK) if (u_bus.DONE === 1'b1) done_cnt = done_cnt + 1;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic bd_write(input logic [7:0] a, input logic [31:0] d);
    bd_we = 1'b1; bd_a = a; bd_d = d;
    @(posedge CK); #1;
    bd_we = 1'b0;
  endtask

  task automatic bd2_write(input logic [1:0] a, input logic [31:0] d);
    bd2_we = 1'b1; bd2_a = a; bd2_d = d;
    @(posedge CK); #1;
    bd2_we = 1'b0;
  endtask

  typedef struct {
    logic [7:0]  addr;
    logic        clr;
    logic        spk;
    logic [31:0] init;
    logic [31:0] exp;
  } vec_t;

  vec_t        tbl [10];
  logic [255:0] sv, in_tbl;
  logic [31:0] img [256];
  logic [31:0] bg_exp;
  int          seq_err, busy_err, done_at, d0, bg_err, lo_err, hi_err;
  logic        exp_cs, exp_we;
  logic [7:0]  exp_a;

  initial begin
    // addr, clr, spike, stored word, expected written word (background 1234_5678)
    tbl[0] = '{8'd0,   1'b0, 1'b0, 32'h8000_0500, 32'h7000_0500};
    tbl[1] = '{8'd5,   1'b0, 1'b1, 32'h8000_0300, 32'h8000_0400};
    tbl[2] = '{8'd7,   1'b0, 1'b0, 32'h0007_2A11, 32'h0007_2A11};
    tbl[3] = '{8'd9,   1'b0, 1'b1, 32'h0000_0000, 32'h1000_0100};
    tbl[4] = '{8'd12,  1'b0, 1'b1, 32'hFFFF_FFAB, 32'hF000_FFAB};
    tbl[5] = '{8'd200, 1'b0, 1'b0, 32'h0008_1000, 32'h0007_1000};
    tbl[6] = '{8'd255, 1'b0, 1'b1, 32'hF800_FE00, 32'hE900_FF00};
    tbl[7] = '{8'd7,   1'b1, 1'b0, 32'h0007_2A11, 32'h0007_0011};
    tbl[8] = '{8'd3,   1'b1, 1'b1, 32'h8000_0500, 32'h8000_0100};
    tbl[9] = '{8'd255, 1'b1, 1'b0, 32'h0010_FF22, 32'h000E_0022};

    u_bus.START = 1'b0;  u_bus.CLR_CNT = 1'b0;  u_bus.SPIKE_VEC = '0;
    u_bus2.START = 1'b0; u_bus2.CLR_CNT = 1'b0; u_bus2.SPIKE_VEC = '0;
    bd_we = 1'b0; bd_a = '0; bd_d = '0;
    bd2_we = 1'b0; bd2_a = '0; bd2_d = '0;

    #1;
    check("reset_outputs",
          64'({u_bus.BUSY, u_bus.DONE, u_bus.SRAM_CS, u_bus.SRAM_WE, u_bus.SRAM_A, u_bus.SRAM_D}), 64'd0);
    check("reset_outputs2",
          64'({u_bus2.BUSY, u_bus2.DONE, u_bus2.SRAM_CS, u_bus2.SRAM_WE, u_bus2.SRAM_A, u_bus2.SRAM_D}), 64'd0);
    repeat (3) @(posedge CK);
    @(negedge CK) RST_N = 1'b1;
    @(posedge CK); #1;

    // Two full sweeps: CLR_CNT=0 then CLR_CNT=1, with timing profile checks on each
    for (int s = 0; s < 2; s++) begin
      sv = '0; in_tbl = '0;
      for (int a = 0; a < 256; a++) img[a] = 32'h1234_5678;
      for (int i = 0; i < 10; i++) begin
        if (tbl[i].clr == (s == 1)) begin
          img[tbl[i].addr]    = tbl[i].init;
          sv[tbl[i].addr]     = tbl[i].spk;
          in_tbl[tbl[i].addr] = 1'b1;
        end
      end
      for (int a = 0; a < 256; a++) bd_write(8'(a), img[a]);

      u_bus.SPIKE_VEC = sv; u_bus.CLR_CNT = (s == 1); u_bus.START = 1'b1;
      @(posedge CK); #1;
      u_bus.START = 1'b0; u_bus.SPIKE_VEC = ~sv; u_bus.CLR_CNT = (s != 1);

      seq_err = 0; busy_err = 0; done_at = 0; d0 = done_cnt;
      for (int c = 1; c <= 520; c++) begin
        @(negedge CK);
        if (c == 100) u_bus.START = 1'b1;
        if (c == 101) u_bus.START = 1'b0;
        exp_cs = (c <= 512);
        exp_we = exp_cs && (c % 2 == 0);
        exp_a  = exp_cs ? 8'((c - 1) / 2) : 8'd0;
        if (u_bus.SRAM_CS !== exp_cs || u_bus.SRAM_WE !== exp_we || u_bus.SRAM_A !== exp_a)
          seq_err++;
        if (u_bus.BUSY !== (c <= 513)) busy_err++;
        if (u_bus.DONE === 1'b1 && done_at == 0) done_at = c;
      end
      check($sformatf("sram_seq_s%0d", s), 64'(seq_err), 64'd0);
      check($sformatf("busy_profile_s%0d", s), 64'(busy_err), 64'd0);
      check($sformatf("done_cycle_s%0d", s), 64'(done_at), 64'd513);
      check($sformatf("done_count_s%0d", s), 64'(done_cnt - d0), 64'd1);

      for (int i = 0; i < 10; i++)
        if (tbl[i].clr == (s == 1))
          check($sformatf("vec%0d_addr%0d", i, tbl[i].addr), 64'(mem[tbl[i].addr]), 64'(tbl[i].exp));
      bg_exp = (s == 1) ? 32'h0FEE_0078 : 32'h0FEE_5678;
      bg_err = 0;
      for (int a = 0; a < 256; a++)
        if (!in_tbl[a] && mem[a] !== bg_exp) bg_err++;
      check($sformatf("background_s%0d", s), 64'(bg_err), 64'd0);
      @(posedge CK); #1;
    end

    // Reset during WR of address 10
    u_bus.CLR_CNT = 1'b0; u_bus.SPIKE_VEC = '0;
    for (int a = 0; a < 256; a++) bd_write(8'(a), 32'h1234_5678);
    u_bus.START = 1'b1;
    @(posedge CK); #1;
    u_bus.START = 1'b0;
    d0 = done_cnt;
    repeat (22) @(negedge CK);
    check("wr10_phase", 64'({u_bus.SRAM_CS, u_bus.SRAM_WE, u_bus.SRAM_A}), 64'({1'b1, 1'b1, 8'd10}));
    RST_N = 1'b0;
    #1;
    check("rst_async_outputs",
          64'({u_bus.BUSY, u_bus.DONE, u_bus.SRAM_CS, u_bus.SRAM_WE, u_bus.SRAM_A, u_bus.SRAM_D}), 64'd0);
    repeat (4) @(negedge CK);
    check("rst_no_done", 64'(done_cnt - d0), 64'd0);
    lo_err = 0; hi_err = 0;
    for (int a = 0; a < 10; a++)   if (mem[a] !== 32'h0FEE_5678) lo_err++;
    for (int a = 10; a < 256; a++) if (mem[a] !== 32'h1234_5678) hi_err++;
    check("rst_written_0_9", 64'(lo_err), 64'd0);
    check("rst_untouched_10_255", 64'(hi_err), 64'd0);

    RST_N = 1'b1;
    @(posedge CK); #1;
    u_bus.START = 1'b1;
    @(posedge CK); #1;
    u_bus.START = 1'b0;
    @(negedge CK);
    check("fresh_first_rd", 64'({u_bus.SRAM_CS, u_bus.SRAM_WE, u_bus.SRAM_A}), 64'({1'b1, 1'b0, 8'd0}));
    done_at = 0;
    for (int c = 2; c <= 600 && done_at == 0; c++) begin
      @(negedge CK);
      if (u_bus.DONE === 1'b1) done_at = c;
    end
    check("fresh_done_cycle", 64'(done_at), 64'd513);
    lo_err = 0; hi_err = 0;
    for (int a = 0; a < 10; a++)   if (mem[a] !== 32'h0DF1_5678) lo_err++;
    for (int a = 10; a < 256; a++) if (mem[a] !== 32'h0FEE_5678) hi_err++;
    check("fresh_words_0_9", 64'(lo_err), 64'd0);
    check("fresh_words_10_255", 64'(hi_err), 64'd0);
    @(posedge CK); #1;

    // Saturating increment with TRACE_INC=16'h4000 on a 4-word instance
    bd2_write(2'd0, 32'hFFF0_FF00);
    bd2_write(2'd1, 32'h0000_0000);
    bd2_write(2'd2, 32'h1000_0000);
    bd2_write(2'd3, 32'hC000_0A00);
    u_bus2.SPIKE_VEC = 4'b1011; u_bus2.START = 1'b1;
    @(posedge CK); #1;
    u_bus2.START = 1'b0; u_bus2.SPIKE_VEC = 4'b0000;
    done_at = 0;
    for (int c = 1; c <= 40 && done_at == 0; c++) begin
      @(negedge CK);
      if (u_bus2.DONE === 1'b1) done_at = c;
    end
    check("sat_done_cycle", 64'(done_at), 64'd9);
    check("sat_word0", 64'(mem2[0]), 64'h0000_0000_FFFF_FF00);
    check("sat_word1", 64'(mem2[1]), 64'h0000_0000_4000_0100);
    check("sat_word2", 64'(mem2[2]), 64'h0000_0000_0E00_0000);
    check("sat_word3", 64'(mem2[3]), 64'h0000_0000_E800_0B00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pre_trace_updater.md
PRE_TRACE_UPDATER -- requirements
Module: pre_trace_updater

Interface
REQ-001 Parameter N_PRE, default 256: number of pre-synaptic neurons swept per time step.
REQ-002 Parameter ADDR_WIDTH, default 8: state SRAM address width; N_PRE SHALL be at most 2^ADDR_WIDTH.
REQ-003 Parameter DATA_WIDTH, default 32: state word width, fixed at 32.
REQ-004 Parameter DECAY_SHIFT, default 3: trace decay as trace - (trace >> DECAY_SHIFT).
REQ-005 Parameter TRACE_INC, default 16'h1000: trace increment applied on a spike.
REQ-006 CK  input  1  clock; all state changes on the rising edge.
REQ-007 RST_N  input  1  asynchronous active-low reset.
REQ-008 START  input  1  single-cycle request to run one time-step sweep.
REQ-009 CLR_CNT  input  1  sampled with START; when 1, spike counts are zeroed during the sweep.
REQ-010 SPIKE_VEC  input  N_PRE  per-neuron spike flags for this time step, sampled with START.
REQ-011 BUSY  output  1  high from the cycle after START is accepted until DONE.
REQ-012 DONE  output  1  single-cycle pulse when the sweep completes.
REQ-013 SRAM_CS  output  1  chip select to the pre-neuron state SRAM.
REQ-014 SRAM_WE  output  1  write enable to the state SRAM.
REQ-015 SRAM_A  output  ADDR_WIDTH  SRAM address.
REQ-016 SRAM_D  output  32  SRAM write data.
REQ-017 SRAM_Q  input  32  SRAM read data, registered and valid the cycle after a CS=1 edge.

Function
REQ-018 The state word format SHALL be: [31:16] trace, unsigned 16 bit; [15:8] spike count, unsigned 8 bit; [7:0] reserved, written back unchanged.
REQ-019 The FSM SHALL have the states IDLE, RD, WR and FIN.
REQ-020 In IDLE, START=1 SHALL latch SPIKE_VEC and CLR_CNT, clear the index to 0, and go to RD.
REQ-021 In RD: CS=1, WE=0, A=index; the next state SHALL be WR.
REQ-022 In WR: CS=1, WE=1, A=index, D=updated word computed combinationally from SRAM_Q.
REQ-023 In WR, if index=N_PRE-1 the next state SHALL be FIN; otherwise the index increments and the next state SHALL be RD.
REQ-024 In FIN: DONE=1 for one cycle, then the next state SHALL be IDLE.
REQ-025 Latency SHALL be exactly 2*N_PRE+1 cycles from the START edge to the DONE cycle, inclusive; with the default, DONE occurs 513 cycles after START.
REQ-026 Trace update: t1 = trace - (trace >> DECAY_SHIFT); if the latched spike bit for the index is set, t2 = min(t1 + TRACE_INC, 16'hFFFF), else t2 = t1; the addition SHALL be 17-bit and saturate.
REQ-027 The decay term SHALL truncate toward zero, so traces smaller than 2^DECAY_SHIFT remain unchanged when there is no spike.
REQ-028 Count update: if the latched CLR_CNT is set, the count base is 0, otherwise the stored count; on a spike, add 1 and saturate at 8'hFF.
REQ-029 START SHALL be ignored in RD, WR and FIN, with no relatch and no restart.
REQ-030 SPIKE_VEC and CLR_CNT changes after acceptance SHALL have no effect on the running sweep.
REQ-031 Outside RD and WR, SRAM_CS and SRAM_WE SHALL be 0.
REQ-032 BUSY SHALL be 1 in RD, WR and FIN, and 0 in IDLE.

Reset
REQ-033 RST_N=0 SHALL immediately force IDLE, index 0, latched flags 0, and BUSY, DONE, SRAM_CS, SRAM_WE, SRAM_A and SRAM_D all 0.
REQ-034 Reset mid-sweep SHALL abandon the sweep without a DONE pulse; addresses already written keep their new values, and the remaining addresses are untouched.
REQ-035 After RST_N rises, the first START SHALL begin a fresh sweep from address 0.

Verification
REQ-036 Decay only: word 32'h8000_0500 at address 0, no spike -> written word 32'h7000_0500.
REQ-037 Spike: word 32'h8000_0300 at address 5, SPIKE_VEC[5]=1 -> written word 32'h8000_0400; all other addresses decay only.
REQ-038 Saturation: TRACE_INC=16'h4000, word 32'h FFF0_FF00 with spike -> written word 32'hFFFF_FF00 (count saturates at 8'hFF).
REQ-039 Small trace and clear: word 32'h0007_2A11 with CLR_CNT=1 and no spike -> written word 32'h0007_0011.
REQ-040 Timing: START at cycle 0 -> SRAM accesses alternate RD/WR for addresses 0..255, DONE at cycle 513, BUSY low from cycle 514; a START pulse at cycle 100 is ignored.
REQ-041 Reset mid-sweep: assert RST_N=0 during WR of address 10 -> outputs go to 0 asynchronously, no DONE, addresses 0-9 are updated and addresses 11 and up are unchanged.
